muldiv_seq: RTL and testbench

// - Multi-cycle sequencer for unsigned 32x32 multiply (MULTU) and divide (DIVU).
// - Reuses the shared 2-bit-op ALU (ADD/SUB/OR/AND, 32-bit, no carry out) as its only adder.
// - Sits beside the EX stage. While alu_req=1 the top level routes the ALU to this block.
// - Results go to HI/LO, which feed MFHI/MFLO.

---
 rtl/muldiv_seq_pkg.sv | 18 +
 rtl/muldiv_seq_if.sv | 16 +
 rtl/muldiv_seq.sv | 135 +++++++++++++
 tb/tb_muldiv_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the multi-cycle MULTU/DIVU sequencer: ALU op codes and FSM states.
package muldiv_seq_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_OR  = 2'b10,
        ALU_AND = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the EX stage (master) and the muldiv sequencer (slave).
interface muldiv_seq_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             start;
    logic             op_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op_div, a, b, input busy, done, hi, lo);
    modport slave  (input start, op_div, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_seq.sv
// Unsigned 32x32 MULTU (shift-add) and DIVU (restoring) sequencer, one bit per cycle,
// borrowing the shared pipeline ALU as its only adder.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITERS = WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    muldiv_seq_if.slave      bus,
    output logic             alu_req_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [1:0]       alu_op_o,
    input  logic [WIDTH-1:0] alu_out_i
);
    localparam int unsigned CntW = $clog2(ITERS);
    localparam logic [CntW-1:0] CntLast = CntW'(ITERS - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    // wh/wl hold P_hi/P_lo for MUL and R/Q for DIV; m holds M or D.
    logic [WIDTH-1:0] wh_q, wh_d, wl_q, wl_d, m_q, m_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    logic             accept, last, carry, ge;
    logic [WIDTH-1:0] rs, mul_hi_n, mul_lo_n, div_r_n, div_q_n;

    assign accept = bus.start && (state_q == S_IDLE || state_q == S_DONE);
    assign last   = (cnt_q == CntLast);

    // The ALU has no carry/borrow out, so both are recovered with local compares.
    assign carry    = (alu_out_i < wh_q);
    assign mul_hi_n = {carry, alu_out_i[WIDTH-1:1]};
    assign mul_lo_n = {alu_out_i[0], wl_q[WIDTH-1:1]};
    assign rs       = {wh_q[WIDTH-2:0], wl_q[WIDTH-1]};
    assign ge       = wh_q[WIDTH-1] | (rs >= m_q);
    assign div_r_n  = ge ? alu_out_i : rs;
    assign div_q_n  = {wl_q[WIDTH-2:0], ge};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start)              state_d = bus.op_div ? S_DIV : S_MUL;
                else if (state_q == S_DONE) state_d = S_IDLE;
            end
            S_MUL, S_DIV: if (last) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        alu_a_o   = '0;
        alu_b_o   = '0;
        alu_op_o  = ALU_ADD;
        unique case (state_q)
            S_MUL: begin
                bus.busy = 1'b1;
                alu_a_o  = wh_q;
                alu_b_o  = wl_q[0] ? m_q : '0;
            end
            S_DIV: begin
                bus.busy = 1'b1;
                alu_a_o  = rs;
                alu_b_o  = m_q;
                alu_op_o = ALU_SUB;
            end
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    assign alu_req_o = bus.busy;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

    always_comb begin
        cnt_d = cnt_q;
        wh_d  = wh_q;
        wl_d  = wl_q;
        m_d   = m_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (accept) begin
            cnt_d = '0;
            wh_d  = '0;
            wl_d  = bus.op_div ? bus.a : bus.b;
            m_d   = bus.op_div ? bus.b : bus.a;
        end else if (state_q == S_MUL) begin
            cnt_d = cnt_q + 1'b1;
            wh_d  = mul_hi_n;
            wl_d  = mul_lo_n;
            if (last) begin
                hi_d = mul_hi_n;
                lo_d = mul_lo_n;
            end
        end else if (state_q == S_DIV) begin
            cnt_d = cnt_q + 1'b1;
            wh_d  = div_r_n;
            wl_d  = div_q_n;
            if (last) begin
                hi_d = div_r_n;
                lo_d = div_q_n;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            wh_q  <= '0;
            wl_q  <= '0;
            m_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            wh_q  <= wh_d;
            wl_q  <= wl_d;
            m_q   <= m_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random MULTU/DIVU traffic.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    muldiv_seq_if bus ();

    logic        alu_req;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [1:0]  alu_op;

    muldiv_seq dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .bus       (bus),
        .alu_req_o (alu_req),
        .alu_a_o   (alu_a),
        .alu_b_o   (alu_b),
        .alu_op_o  (alu_op),
        .alu_out_i (alu_out)
    );

    // Shared pipeline ALU stand-in: 32-bit, no carry out.
    always_comb begin
        case (alu_op)
            2'b00:   alu_out = alu_a + alu_b;
            2'b01:   alu_out = alu_a - alu_b;
            2'b10:   alu_out = alu_a | alu_b;
            default: alu_out = alu_a & alu_b;
        endcase
    end

    int          vectors = 0;
    int          fails   = 0;
    logic [63:0] held;

    function automatic logic [63:0] model(input bit op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        if (!op) begin
            p = {32'd0, a} * {32'd0, b};
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input bit op, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.op_div = op;
        bus.a      = a;
        bus.b      = b;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    // Walks the 32 busy cycles; optionally pulses start mid-operation.
    task automatic track(input string tag, input int inject_at);
        bit ok = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            ok &= (bus.busy === 1'b1) && (bus.done === 1'b0) && (alu_req === 1'b1);
            ok &= ({bus.hi, bus.lo} === held);
            if (i == inject_at) begin
                bus.start  = 1'b1;
                bus.op_div = 1'($urandom);
                bus.a      = $urandom;
                bus.b      = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, " busy window"}, {63'd0, ok}, 64'd1);
    endtask

    task automatic finish_op(input string tag, input logic [63:0] exp);
        check({tag, " done pulse"}, {62'd0, bus.busy, bus.done}, 64'd1);
        check({tag, " hi/lo"}, {bus.hi, bus.lo}, exp);
        held = exp;
    endtask

    task automatic run_op(input string tag, input bit op, input logic [31:0] a,
                          input logic [31:0] b, input int inject_at);
        @(negedge clk);
        check({tag, " idle state"}, {62'd0, bus.busy, bus.done}, 64'd0);
        check({tag, " idle alu"}, {alu_a, alu_b}, 64'd0);
        issue(op, a, b);
        track(tag, inject_at);
        finish_op(tag, model(op, a, b));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1);
    end

    initial begin
        bit          ok;
        bit          op;
        logic [31:0] ra, rb;

        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op_div = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        held       = '0;
        #1;
        check("reset busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
        check("reset hi/lo", {bus.hi, bus.lo}, 64'd0);
        check("reset alu ab", {alu_a, alu_b}, 64'd0);
        check("reset alu req/op", {61'd0, alu_req, alu_op}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul 7*6", 1'b0, 32'd7, 32'd6, 0);
        run_op("mul ffff*ffff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("div 100/7", 1'b1, 32'd100, 32'd7, 0);
        run_op("div 8000_0000/3", 1'b1, 32'h8000_0000, 32'd3, 0);
        run_op("div 5/0", 1'b1, 32'd5, 32'd0, 0);
        run_op("start while busy", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 7);

        // Back-to-back: second op launched in the DONE cycle of the first.
        run_op("b2b first", 1'b1, 32'hDEAD_BEEF, 32'd13, 0);
        issue(1'b0, 32'hCAFE_F00D, 32'h0BAD_F00D);
        track("b2b second", 0);
        finish_op("b2b second", model(1'b0, 32'hCAFE_F00D, 32'h0BAD_F00D));

        // Reset around iteration 10 aborts without a done pulse.
        @(negedge clk);
        issue(1'b0, $urandom, $urandom);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
        check("abort hi/lo", {bus.hi, bus.lo}, 64'd0);
        check("abort alu ab", {alu_a, alu_b}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        held  = '0;
        ok    = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ok &= (bus.done === 1'b0) && (bus.busy === 1'b0);
        end
        check("abort no done", {63'd0, ok}, 64'd1);
        run_op("mul 3*3 after abort", 1'b0, 32'd3, 32'd3, 0);

        for (int k = 0; k < 24; k++) begin
            op = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom_range(0, 15);
                1:       rb = ra >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if (k % 3 == 0) begin
                issue(op, ra, rb);
                track("rand b2b", 0);
                finish_op("rand b2b", model(op, ra, rb));
            end else begin
                run_op(op ? "rand div" : "rand mul", op, ra, rb, (k % 4 == 1) ? 20 : 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
